// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet receive path: FSM encoding,
// default start-of-frame marker and error-pulse bit indices.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam int NUM_ERR = 5;
  localparam int ERR_LEN = 0;
  localparam int ERR_CHK = 1;
  localparam int ERR_BRK = 2;
  localparam int ERR_TMO = 3;
  localparam int ERR_OVR = 4;

  function automatic logic [NUM_ERR-1:0] err_bit(input int idx);
    return NUM_ERR'(1) << idx;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind a UART receiver: SOF, length, payload, XOR checksum,
// then drains the payload as a valid/ready stream. Optional inter-byte
// timeout is compiled in with UART_RX_PKT_CTRL_TIMEOUT_EN.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 208333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       rx_en,
  input  logic       rx_valid,
  input  logic       rx_break,
  input  logic [7:0] rx_data,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_brk,
  output logic       err_tmo,
  output logic       err_ovr,
  output logic       busy
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e             state_q;
  logic [CW-1:0]      len_q;
  logic [CW-1:0]      cnt_q;
  logic [7:0]         chk_q;
  logic               rx_en_q;
  logic               pkt_valid_q;
  logic               pkt_last_q;
  logic [7:0]         pkt_data_q;
  logic [NUM_ERR-1:0] err_q;

  logic               buf_we_d;
  logic [AW-1:0]      raddr_d;
  logic [7:0]         buf_rdata;

`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
`endif

  // Payload bytes land in the buffer only when the FSM accepts them.
  assign buf_we_d = (state_q == ST_PAYLOAD) && enable && !rx_break && rx_valid;
  // In CHK the read port pre-fetches byte 0 so DRAIN can start with data.
  assign raddr_d  = (state_q == ST_CHK) ? '0 : cnt_q[AW-1:0];

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we_d),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (rx_data),
    .raddr_i (raddr_d),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      chk_q       <= '0;
      rx_en_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      pkt_data_q  <= 8'h00;
      err_q       <= '0;
`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      rx_en_q <= enable;
      err_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (enable && rx_valid && rx_data == SOF_BYTE) begin
            state_q <= ST_LEN;
            cnt_q   <= '0;
            chk_q   <= '0;
`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
            tmo_q   <= TW'(TIMEOUT_CYCLES);
`endif
          end
        end
        ST_LEN, ST_PAYLOAD, ST_CHK: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (rx_break) begin
            err_q   <= err_bit(ERR_BRK);
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
            tmo_q <= TW'(TIMEOUT_CYCLES);
`endif
            case (state_q)
              ST_LEN: begin
                if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) begin
                  err_q   <= err_bit(ERR_LEN);
                  state_q <= ST_IDLE;
                end else begin
                  len_q   <= rx_data[CW-1:0];
                  chk_q   <= rx_data;
                  cnt_q   <= '0;
                  state_q <= ST_PAYLOAD;
                end
              end
              ST_PAYLOAD: begin
                chk_q <= chk_q ^ rx_data;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == len_q - 1'b1) state_q <= ST_CHK;
              end
              default: begin
                if (rx_data == chk_q) begin
                  state_q     <= ST_DRAIN;
                  pkt_valid_q <= 1'b1;
                  pkt_data_q  <= buf_rdata;
                  pkt_last_q  <= (len_q == CW'(1));
                  cnt_q       <= CW'(1);
                end else begin
                  err_q   <= err_bit(ERR_CHK);
                  state_q <= ST_IDLE;
                end
              end
            endcase
          end
`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
          else if (tmo_q == TW'(1)) begin
            err_q   <= err_bit(ERR_TMO);
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
`endif
        end
        ST_DRAIN: begin
          // Enable and break are ignored here; the packet always finishes.
          if (rx_valid) err_q <= err_bit(ERR_OVR);
          if (pkt_ready) begin
            if (pkt_last_q) begin
              state_q     <= ST_IDLE;
              pkt_valid_q <= 1'b0;
              pkt_last_q  <= 1'b0;
              cnt_q       <= '0;
            end else begin
              pkt_data_q <= buf_rdata;
              pkt_last_q <= (cnt_q == len_q - 1'b1);
              cnt_q      <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_en     = rx_en_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_last  = pkt_last_q;
  assign pkt_data  = pkt_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_len   = err_q[ERR_LEN];
  assign err_chk   = err_q[ERR_CHK];
  assign err_brk   = err_q[ERR_BRK];
  // Never set when the timeout is compiled out, so this stays 0.
  assign err_tmo   = err_q[ERR_TMO];
  assign err_ovr   = err_q[ERR_OVR];

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: directed frames then random traffic,
// checked against a byte-level packet model.
module tb_uart_rx_pkt_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;
  localparam int E_LEN = 0, E_CHK = 1, E_BRK = 2, E_TMO = 3, E_OVR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       rx_en;
  logic       rx_valid = 1'b0;
  logic       rx_break = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] pkt_data;
  logic       pkt_valid, pkt_last;
  logic       pkt_ready = 1'b1;
  logic       err_len, err_chk, err_brk, err_tmo, err_ovr, busy;

  uart_rx_pkt_ctrl #(.MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_en(rx_en),
    .rx_valid(rx_valid), .rx_break(rx_break), .rx_data(rx_data),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
    .err_len(err_len), .err_chk(err_chk), .err_brk(err_brk), .err_tmo(err_tmo),
    .err_ovr(err_ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  bit         m_in_frame = 0;
  byte unsigned m_frame[$];
  int         m_drain = 0;
  int         m_silent = 0;
  bit         m_en_prev = 0;
  logic [8:0] exp_pkt[$];
  int         exp_err[$];
  bit         exp_valid = 0, exp_busy = 0, exp_rxen = 0;

  task automatic model_step(input bit v, input bit b, input byte unsigned d);
    byte unsigned x;
    int len;
    if (reset) begin
      m_in_frame = 0; m_frame.delete(); m_drain = 0; m_silent = 0;
      return;
    end
    if (m_drain > 0) begin
      if (v) exp_err.push_back(E_OVR);
      if (pkt_ready) m_drain--;
      return;
    end
    if (!m_in_frame) begin
      if (v && enable && d == 8'hA5) begin
        m_in_frame = 1; m_frame.delete(); m_silent = 0;
      end
      return;
    end
    if (!enable) begin
      m_in_frame = 0;
    end else if (b) begin
      exp_err.push_back(E_BRK); m_in_frame = 0;
    end else if (v) begin
      m_silent = 0;
      if (m_frame.size() == 0) begin
        if (d == 0 || int'(d) > MAX_LEN) begin
          exp_err.push_back(E_LEN); m_in_frame = 0;
        end else m_frame.push_back(d);
      end else if (m_frame.size() < 1 + int'(m_frame[0])) begin
        m_frame.push_back(d);
      end else begin
        x = 0;
        foreach (m_frame[i]) x ^= m_frame[i];
        len = int'(m_frame[0]);
        if (x == d) begin
          for (int i = 1; i <= len; i++) exp_pkt.push_back({(i == len), m_frame[i]});
          m_drain = len;
        end else exp_err.push_back(E_CHK);
        m_in_frame = 0;
      end
    end else begin
`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
      m_silent++;
      if (m_silent == TMO) begin
        exp_err.push_back(E_TMO); m_in_frame = 0;
      end
`endif
    end
  endtask

  // One clock: drive inputs, publish expectations for this cycle, advance model.
  task automatic cycle(input bit v, input bit b, input byte unsigned d);
    rx_valid = v; rx_break = b; rx_data = d;
    exp_valid = (m_drain > 0);
    exp_busy  = (m_drain > 0) || m_in_frame;
    exp_rxen  = m_en_prev;
    model_step(v, b, d);
    m_en_prev = reset ? 1'b0 : enable;
    @(posedge clk); #1;
  endtask

  byte unsigned sq[$];
  task automatic send_q();
    foreach (sq[i]) cycle(1, 0, sq[i]);
    sq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 8'h00);
  endtask

  // ---------------- monitor ----------------
  bit         mon_on = 0;
  int         cyc = 0;
  int         tmo_cyc = -1;
  bit         stall_prev = 0;
  logic [8:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      int nerr, code;
      logic [8:0] e;
      nerr = int'(err_len) + int'(err_chk) + int'(err_brk) + int'(err_tmo) + int'(err_ovr);
      if (err_tmo) tmo_cyc = cyc;
      if (nerr > 1) check("single_err", 32'(nerr), 32'd1);
      else if (nerr == 1) begin
        code = err_len ? E_LEN : err_chk ? E_CHK : err_brk ? E_BRK : err_tmo ? E_TMO : E_OVR;
        if (exp_err.size() == 0) check("unexpected_err", 32'(code), 32'hFF);
        else check("err_kind", 32'(code), 32'(exp_err.pop_front()));
      end
      check("pkt_valid", 32'(pkt_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_busy));
      check("rx_en", 32'(rx_en), 32'(exp_rxen));
      if (stall_prev && pkt_valid) check("hold", 32'({pkt_last, pkt_data}), 32'(held));
      if (pkt_valid && pkt_ready) begin
        if (exp_pkt.size() == 0) check("unexpected_pkt", 32'({pkt_last, pkt_data}), 32'h1FF);
        else begin
          e = exp_pkt.pop_front();
          check("pkt_byte", 32'({pkt_last, pkt_data}), 32'(e));
        end
      end
      stall_prev = pkt_valid && !pkt_ready;
      held = {pkt_last, pkt_data};
    end
  end

  // ---------------- stimulus ----------------
  task automatic rcycle(input bit v, input bit b, input byte unsigned d);
    pkt_ready = ($urandom_range(0, 3) != 0);
    enable    = ($urandom_range(0, 80) != 0);
    cycle(v, b, d);
  endtask

  task automatic rsend(input byte unsigned d);
    repeat ($urandom_range(0, 2)) rcycle(0, 0, 8'h00);
    rcycle(1, ($urandom_range(0, 60) == 0), d);
  endtask

  initial begin
    int acc_cyc, len, kind, bound;
    byte unsigned x, p;

    reset = 1; enable = 0;
    repeat (3) cycle(0, 0, 8'h00);
    reset = 0;
    #2;
    check("rst_outputs", 32'({rx_en, pkt_valid, pkt_last, busy, err_len, err_chk, err_brk, err_tmo, err_ovr}), 32'd0);
    check("rst_pkt_data", 32'(pkt_data), 32'h00);
    mon_on = 1;
    enable = 1; pkt_ready = 1;
    idle(2);

    // good 3-byte packet
    sq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}; send_q(); idle(6);
    // bad checksum
    sq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04}; send_q(); idle(3);
    check("chk_idle", 32'(busy), 32'd0);
    // illegal lengths
    sq = '{8'hA5, 8'h00}; send_q(); idle(2);
    sq = '{8'hA5, 8'h11}; send_q(); idle(2);
    // break mid-payload, then a 1-byte packet with trailing garbage
    sq = '{8'hA5, 8'h02, 8'h44}; send_q();
    cycle(1, 1, 8'h00); idle(2);
    sq = '{8'hA5, 8'h01, 8'h7E, 8'h7F}; send_q(); idle(4);
    // overrun while stalled
    pkt_ready = 0;
    sq = '{8'hA5, 8'h02, 8'h55, 8'h66, 8'h31}; send_q(); idle(2);
    cycle(1, 0, 8'h99); idle(3);
    pkt_ready = 1; idle(4);
    // inter-byte silence
    sq = '{8'hA5, 8'h02, 8'h11}; send_q();
    acc_cyc = cyc; tmo_cyc = -1;
    idle(TMO + 20);
`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
    check("tmo_latency", 32'(tmo_cyc - acc_cyc), 32'(TMO));
`else
    check("tmo_absent", 32'(tmo_cyc), 32'hFFFF_FFFF);
    check("tmo_busy", 32'(busy), 32'd1);
    enable = 0; idle(1); enable = 1; idle(1);
`endif
    // reset mid-packet and mid-drain: no error, packet dropped
    sq = '{8'hA5, 8'h03, 8'h11}; send_q();
    reset = 1; idle(1); reset = 0; idle(2);
    pkt_ready = 0;
    sq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01}; send_q(); idle(2);
    reset = 1; exp_pkt.delete(); idle(1); reset = 0; pkt_ready = 1; idle(2);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rsend(8'($urandom));
      end else begin
        len = (kind == 1) ? $urandom_range(0, 40) : $urandom_range(1, MAX_LEN);
        rsend(8'hA5);
        rsend(8'(len));
        x = 8'(len);
        for (int i = 0; i < len && i < MAX_LEN; i++) begin
          p = 8'($urandom); x ^= p; rsend(p);
        end
        rsend((kind == 2) ? 8'(x ^ 8'h5A) : x);
      end
    end

    enable = 1; pkt_ready = 1;
    bound = 0;
    while ((exp_pkt.size() != 0 || m_drain > 0) && bound < 200) begin
      cycle(0, 0, 8'h00); bound++;
    end
    idle(3);
    check("pkt_queue_empty", 32'(exp_pkt.size()), 32'd0);
    check("err_queue_empty", 32'(exp_err.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum payload bytes per packet (legal 1..255).
REQ-002 SHALL have parameter SOF_BYTE, default 8'hA5, meaning the start-of-frame marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 208333, meaning the inter-byte timeout in clk cycles (two byte times at 9600 baud, 100 MHz).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, the reset; reset is synchronous and active-high.
REQ-006 SHALL have port enable, input, 1, the controller enable.
REQ-007 SHALL have port rx_en, output, 1, driving uart_rx_en of the receiver.
REQ-008 SHALL have ports rx_valid, rx_break (inputs, 1 each) and rx_data (input, 8), taken from the receiver outputs.
REQ-009 SHALL have ports pkt_data (output, 8), pkt_valid (output, 1), pkt_last (output, 1) and pkt_ready (input, 1), forming the payload stream.
REQ-010 SHALL have outputs err_len, err_chk, err_brk, err_tmo and err_ovr (1 each), each a single-cycle error pulse.
REQ-011 SHALL have output busy, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, LEN, PAYLOAD, CHK and DRAIN.
REQ-013 SHALL register rx_en, equal to enable delayed by one cycle.
REQ-014 SHALL, in IDLE, go to LEN on an accepted byte equal to SOF_BYTE, and discard any other byte silently.
REQ-015 SHALL, in LEN, on a byte L: if L is 0 or greater than MAX_LEN, pulse err_len and go to IDLE; otherwise store L, seed the checksum with L, and go to PAYLOAD.
REQ-016 SHALL, in PAYLOAD, write each byte to buffer index 0..L-1, XOR it into the checksum, and go to CHK after the L-th byte.
REQ-017 SHALL, in CHK, go to DRAIN on a byte equal to the 8-bit checksum; on any other byte it SHALL pulse err_chk and go to IDLE.
REQ-018 SHALL, in DRAIN, assert pkt_valid beginning the cycle after the CHK byte (latency 1).
REQ-019 SHALL, in DRAIN, present buffer[rd] on pkt_data and advance rd on a cycle where pkt_valid and pkt_ready are both high.
REQ-020 SHALL hold pkt_data and pkt_last stable while pkt_valid is high and pkt_ready is low.
REQ-021 SHALL assert pkt_last with the byte at index L-1, and go to IDLE on that byte's handshake.
REQ-022 SHALL, in DRAIN, discard any rx_valid byte and pulse err_ovr.
REQ-023 SHALL, in LEN, PAYLOAD or CHK, treat rx_break as an abort: pulse err_brk, drop the associated byte and go to IDLE; rx_break has priority over rx_valid in the same cycle.
REQ-024 SHALL, in IDLE and DRAIN, ignore rx_break.
REQ-025 SHALL, when enable is low in LEN, PAYLOAD or CHK, go to IDLE with no error pulse.
REQ-026 SHALL, when enable is low in DRAIN, complete the drain.
REQ-027 SHALL size the checksum and all counters so that wrap-around never occurs within MAX_LEN.
REQ-028 SHALL never assert more than one error pulse in a cycle.

Reset
REQ-029 SHALL, on reset, enter IDLE and drive rx_en, pkt_valid, pkt_last, busy and all err_* to 0, pkt_data to 8'h00, and clear the counters and checksum.
REQ-030 SHALL, on reset mid-packet or mid-drain, discard the packet with no error pulse.
REQ-031 SHALL leave the buffer contents unreset.

Configuration
REQ-032 SHALL, with UART_RX_PKT_CTRL_TIMEOUT_EN defined, reload the timeout counter on entry to LEN and on every accepted byte in LEN, PAYLOAD or CHK.
REQ-033 SHALL, with UART_RX_PKT_CTRL_TIMEOUT_EN defined, pulse err_tmo and go to IDLE when TIMEOUT_CYCLES elapse with no accepted byte; an rx_valid in the expiry cycle wins and reloads the counter.
REQ-034 SHALL, without UART_RX_PKT_CTRL_TIMEOUT_EN, contain no timeout counter and tie err_tmo to 0.

Structure
REQ-035 SHALL take the FSM state encoding, the SOF_BYTE default and the error-index constants from shared package uart_pkg.
REQ-036 SHALL place the payload storage (MAX_LEN x 8, one write port, one read port) in sub-module uart_pkt_buf.

Verification
REQ-037 SHALL cover: A5 03 11 22 33 03 with pkt_ready=1 -> pkt_data 11,22,33 on consecutive cycles, pkt_last with 33, and no err_*.
REQ-038 SHALL cover: A5 03 11 22 33 04 -> one err_chk pulse, no pkt_valid, FSM in IDLE.
REQ-039 SHALL cover: A5 00 and A5 11 (MAX_LEN=16) -> err_len pulse for each, no pkt_valid.
REQ-040 SHALL cover: A5 02 44, then rx_break with rx_valid and 00 in the same cycle -> err_brk only, IDLE; a following A5 01 7E 7F is delivered as 7E with pkt_last.
REQ-041 SHALL cover: pkt_ready=0 in DRAIN with a byte arriving -> err_ovr pulse, pkt_data held unchanged, the drain resumes when pkt_ready goes high.
REQ-042 SHALL cover, with the macro and TIMEOUT_CYCLES=100: A5 02 11 then silence -> err_tmo 100 cycles after the 11; without the macro, err_tmo stays 0 and busy stays 1.
